// File: rtl/wordle_grader.sv
// wordle_grader: grades one five-letter guess against a secret, Wordle rules.
// Ports: Clk/reset, start/new_game/guess/secret in; busy/done/err/colors/hist_*/row/win/lose out.
module wordle_grader #(
  parameter int MAX_GUESSES = 6
) (
  input  logic        Clk,
  input  logic        reset,
  input  logic        start,
  input  logic        new_game,
  input  logic [39:0] guess,
  input  logic [39:0] secret,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [9:0]  colors,
  output logic        hist_we,
  output logic [2:0]  hist_row,
  output logic [49:0] hist_data,
  output logic [2:0]  row,
  output logic        win,
  output logic        lose
);

  typedef enum logic [2:0] {
    IDLE,
    GREEN,
    YELLOW,
    WRITE,
    REPORT
  } state_t;

  localparam logic [2:0] MAX_ROW = 3'(MAX_GUESSES);
  localparam logic [3:0] MAX_W   = 4'(MAX_GUESSES);

  state_t      state;
  logic [39:0] gl;
  logic        chk;
  logic [4:0]  used;
  logic [2:0]  ii;
  logic [2:0]  jj;

  logic [7:0]  gi;
  logic [7:0]  si;
  logic [7:0]  sj;
  logic [7:0]  lk;
  logic [1:0]  ci;
  logic        letters_ok;
  logic        g_hit;
  logic        y_hit;
  logic [9:0]  gcolors;
  logic [9:0]  ycolors;
  logic [9:0]  filled;
  logic [2:0]  row_inc;
  logic        win_n;
  logic        lose_n;

  function automatic logic [7:0] ltr(
    input logic [39:0] w,
    input logic [2:0]  k
  );
    logic [7:0] r;
    case (k)
      3'd0:    r = w[39:32];
      3'd1:    r = w[31:24];
      3'd2:    r = w[23:16];
      3'd3:    r = w[15:8];
      3'd4:    r = w[7:0];
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  function automatic logic [1:0] slot(
    input logic [9:0] c,
    input logic [2:0] k
  );
    logic [1:0] r;
    case (k)
      3'd0:    r = c[9:8];
      3'd1:    r = c[7:6];
      3'd2:    r = c[5:4];
      3'd3:    r = c[3:2];
      3'd4:    r = c[1:0];
      default: r = 2'b00;
    endcase
    return r;
  endfunction

  function automatic logic [9:0] put(
    input logic [9:0] c,
    input logic [2:0] k,
    input logic [1:0] v
  );
    logic [9:0] r;
    r = c;
    for (int n = 0; n < 5; n++)
      if (3'(n) == k) r[8-2*n +: 2] = v;
    return r;
  endfunction

  // Any letter still empty after the yellow pass becomes gray.
  function automatic logic [9:0] fill(
    input logic [9:0] c
  );
    logic [9:0] r;
    r = c;
    for (int n = 0; n < 5; n++)
      if (r[2*n +: 2] == 2'b00) r[2*n +: 2] = 2'b01;
    return r;
  endfunction

  always_comb begin
    gi         = ltr(gl, ii);
    si         = ltr(secret, ii);
    sj         = ltr(secret, jj);
    ci         = slot(colors, ii);
    letters_ok = 1'b1;
    lk         = 8'h00;
    for (int k = 0; k < 5; k++) begin
      lk = ltr(gl, 3'(k));
      if (lk < 8'h41 || lk > 8'h5A)
        letters_ok = 1'b0;
    end
    g_hit   = (gi == si);
    y_hit   = (ci == 2'b00) && !used[jj]
              && (gi == sj);
    gcolors = put(colors, ii, 2'b11);
    ycolors = y_hit ? put(colors, ii, 2'b10)
                    : colors;
    filled  = fill(ycolors);
    row_inc = (row < MAX_ROW) ? row + 3'd1 : row;
    win_n   = (colors == 10'h3FF);
    lose_n  = !win_n
              && ({1'b0, row} + 4'd1 == MAX_W);
  end

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      gl        <= '0;
      chk       <= 1'b0;
      used      <= '0;
      ii        <= '0;
      jj        <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      colors    <= '0;
      hist_we   <= 1'b0;
      hist_row  <= '0;
      hist_data <= '0;
      row       <= '0;
      win       <= 1'b0;
      lose      <= 1'b0;
    end else begin
      err     <= 1'b0;
      done    <= 1'b0;
      hist_we <= 1'b0;
      // new_game wins over everything, including an in-flight grade.
      if (new_game) begin
        state  <= IDLE;
        chk    <= 1'b0;
        busy   <= 1'b0;
        row    <= '0;
        win    <= 1'b0;
        lose   <= 1'b0;
        colors <= '0;
      end else begin
        unique case (state)
          IDLE: begin
            // One cycle after the latch the letters are vetted.
            if (chk) begin
              chk <= 1'b0;
              if (!letters_ok) begin
                err <= 1'b1;
              end else begin
                colors <= '0;
                used   <= '0;
                ii     <= '0;
                busy   <= 1'b1;
                state  <= GREEN;
              end
            end else if (start && !(win || lose)) begin
              gl  <= guess;
              chk <= 1'b1;
            end
          end
          GREEN: begin
            if (g_hit) begin
              colors   <= gcolors;
              used[ii] <= 1'b1;
            end
            if (ii == 3'd4) begin
              ii    <= '0;
              jj    <= '0;
              state <= YELLOW;
            end else begin
              ii <= ii + 3'd1;
            end
          end
          YELLOW: begin
            if (y_hit) used[jj] <= 1'b1;
            colors <= ycolors;
            if (jj == 3'd4) begin
              jj <= '0;
              if (ii == 3'd4) begin
                colors    <= filled;
                hist_we   <= 1'b1;
                hist_row  <= row;
                hist_data <= {gl, filled};
                state     <= WRITE;
              end else begin
                ii <= ii + 3'd1;
              end
            end else begin
              jj <= jj + 3'd1;
            end
          end
          WRITE: begin
            done  <= 1'b1;
            row   <= row_inc;
            win   <= win_n;
            lose  <= lose_n;
            state <= REPORT;
          end
          REPORT: begin
            busy  <= 1'b0;
            state <= IDLE;
          end
          default: begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_wordle_grader.sv
// tb_wordle_grader: directed stimulus, queued expectations, negedge monitor.
// Checks colors, history writes, latency, flags, err, abort and reset.
module tb_wordle_grader;

  logic        Clk = 1'b0;
  logic        reset;
  logic        start;
  logic        new_game;
  logic [39:0] guess;
  logic [39:0] secret;
  logic        busy;
  logic        done;
  logic        err;
  logic [9:0]  colors;
  logic        hist_we;
  logic [2:0]  hist_row;
  logic [49:0] hist_data;
  logic [2:0]  row;
  logic        win;
  logic        lose;

  wordle_grader #(.MAX_GUESSES(6)) dut (
    .Clk       (Clk),
    .reset     (reset),
    .start     (start),
    .new_game  (new_game),
    .guess     (guess),
    .secret    (secret),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .colors    (colors),
    .hist_we   (hist_we),
    .hist_row  (hist_row),
    .hist_data (hist_data),
    .row       (row),
    .win       (win),
    .lose      (lose)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    int          t0;
    logic [2:0]  hrow;
    logic [49:0] hdata;
    logic [9:0]  col;
    logic        w;
    logic        l;
    logic [2:0]  nrow;
  } exp_t;

  int   checks  = 0;
  int   errors  = 0;
  int   cyc     = 0;
  int   err_cnt = 0;
  exp_t q[$];
  exp_t cur;
  bit   cur_v   = 1'b0;
  logic [2:0] mrow = 3'd0;

  always @(posedge Clk) cyc = cyc + 1;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  always @(negedge Clk) begin
    if (err === 1'b1) err_cnt = err_cnt + 1;
    if (hist_we === 1'b1) begin
      if (q.size() == 0) begin
        chk("unexpected_hist_we", 1, 0);
      end else begin
        cur   = q.pop_front();
        cur_v = 1'b1;
        chk("hist_latency", 64'(cyc - cur.t0), 31);
        chk("hist_row", 64'(hist_row), 64'(cur.hrow));
        chk("hist_data", 64'(hist_data), 64'(cur.hdata));
      end
    end
    if (done === 1'b1) begin
      if (!cur_v) begin
        chk("unexpected_done", 1, 0);
      end else begin
        chk("done_latency", 64'(cyc - cur.t0), 32);
        chk("colors", 64'(colors), 64'(cur.col));
        chk("win", 64'(win), 64'(cur.w));
        chk("lose", 64'(lose), 64'(cur.l));
        chk("row", 64'(row), 64'(cur.nrow));
        cur_v = 1'b0;
      end
    end
  end

  task automatic pulse_start(input logic [39:0] g);
    guess = g;
    start = 1'b1;
    @(negedge Clk);
    start = 1'b0;
  endtask

  task automatic grade(input logic [39:0] g,
                       input logic [9:0]  col,
                       input logic        w,
                       input logic        l);
    exp_t e;
    e.t0    = cyc + 1;
    e.hrow  = mrow;
    e.hdata = {g, col};
    e.col   = col;
    e.w     = w;
    e.l     = l;
    e.nrow  = mrow + 3'd1;
    mrow    = e.nrow;
    q.push_back(e);
    pulse_start(g);
    repeat (36) @(negedge Clk);
    chk("drained", 64'(q.size()) + 64'(cur_v), 0);
  endtask

  task automatic do_new_game();
    new_game = 1'b1;
    @(negedge Clk);
    new_game = 1'b0;
    mrow = 3'd0;
  endtask

  task automatic check_zero(input string name);
    chk({name, "_ctl"},
        {49'd0, busy, done, err, colors, hist_we,
         hist_row, row, win, lose}, 0);
    chk({name, "_hdata"}, 64'(hist_data), 0);
  endtask

  int e0;

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    new_game = 1'b0;
    guess    = "AAAAA";
    secret   = "CRANE";
    repeat (2) @(negedge Clk);
    check_zero("reset");
    reset = 1'b0;
    @(negedge Clk);

    grade("CRANE", 10'h3FF, 1'b1, 1'b0);
    pulse_start("CRANE");
    repeat (3) @(negedge Clk);
    chk("won_start_busy", 64'(busy), 0);
    chk("won_row", 64'(row), 1);

    do_new_game();
    chk("ng_row", 64'(row), 0);
    chk("ng_win_colors", {53'd0, win, colors}, 0);
    grade("EERIE", 10'h167, 1'b0, 1'b0);

    do_new_game();
    secret = "ABBEY";
    grade("BOBBY", 10'h277, 1'b0, 1'b0);

    do_new_game();
    secret = "CRANE";
    for (int i = 0; i < 6; i++)
      grade("ZZZZZ", 10'h155, 1'b0, i == 5);
    chk("lost_flag", 64'(lose), 1);
    chk("lost_row", 64'(row), 6);
    pulse_start("CRANE");
    repeat (3) @(negedge Clk);
    chk("lost_start_busy", 64'(busy), 0);
    chk("lost_row_hold", 64'(row), 6);

    do_new_game();
    grade("CRANK", 10'h3FD, 1'b0, 1'b0);
    e0 = err_cnt;
    pulse_start("CR NE");
    chk("err_early", 64'(err), 0);
    @(negedge Clk);
    chk("err_pulse", 64'(err), 1);
    @(negedge Clk);
    chk("err_width", 64'(err), 0);
    repeat (3) @(negedge Clk);
    chk("err_count", 64'(err_cnt - e0), 1);
    chk("err_busy", 64'(busy), 0);
    chk("err_row", 64'(row), 1);
    chk("err_colors", 64'(colors), 64'(10'h3FD));

    do_new_game();
    pulse_start("EERIE");
    repeat (16) @(negedge Clk);
    chk("busy_in_yellow", 64'(busy), 1);
    reset = 1'b1;
    #1;
    check_zero("midreset");
    @(negedge Clk);
    reset = 1'b0;
    repeat (40) @(negedge Clk);
    mrow = 3'd0;
    grade("EERIE", 10'h167, 1'b0, 1'b0);

    do_new_game();
    pulse_start("CRANE");
    @(negedge Clk);
    chk("busy_in_green", 64'(busy), 1);
    new_game = 1'b1;
    @(negedge Clk);
    new_game = 1'b0;
    mrow = 3'd0;
    chk("abort_busy", 64'(busy), 0);
    chk("abort_row", 64'(row), 0);
    repeat (40) @(negedge Clk);
    chk("abort_quiet", 64'(q.size()) + 64'(cur_v), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/wordle_grader.md
WORDLE_GRADER -- requirements
Module: wordle_grader

Interface
REQ-001 SHALL have parameter MAX_GUESSES, default 6, meaning the number of graded guesses per game (range 1..7).
REQ-002 SHALL have port Clk  input  1  system clock; all state changes occur on the rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port start  input  1  request to grade `guess`; sampled on the rising edge.
REQ-005 SHALL have port new_game  input  1  clear game state; sampled on the rising edge.
REQ-006 SHALL have port guess  input  40  five ASCII letters; letter0 is in [39:32] and letter4 is in [7:0].
REQ-007 SHALL have port secret  input  40  answer word, same packing as `guess`; held stable by the source for the whole game.
REQ-008 SHALL have port busy  output  1  high while grading is in progress (states GREEN through REPORT).
REQ-009 SHALL have port done  output  1  one-cycle pulse at the end of grading.
REQ-010 SHALL have port err  output  1  one-cycle pulse when a start is rejected because a letter is invalid.
REQ-011 SHALL have port colors  output  10  two bits per letter: letter0 in [9:8]; encoding 00 empty, 01 gray, 10 yellow, 11 green.
REQ-012 SHALL have port hist_we, hist_row, hist_data  outputs  1/3/50  history write port; hist_data is {guess, colors}.
REQ-013 SHALL have port row  output  3  number of guesses graded in this game.
REQ-014 SHALL have ports win and lose  outputs  1/1  sticky game result flags.

Function
REQ-015 SHALL implement the states IDLE, GREEN, YELLOW, WRITE and REPORT.
REQ-016 In IDLE, when new_game=1, SHALL clear row, win, lose and colors on the next edge; new_game has priority over a simultaneous start.
REQ-017 In IDLE, when start=1 and game_over (win|lose) is 0, SHALL latch guess and check it; game_over=1 means the start is ignored with no pulse.
REQ-018 SHALL consider a letter valid only if it is in 8'h41..8'h5A; if any latched letter is invalid, SHALL pulse err one cycle after the start edge, stay in IDLE, and leave row and colors unchanged.
REQ-019 On a valid start, SHALL clear colors and the used mask, then enter GREEN.
REQ-020 GREEN SHALL take 5 cycles (i = 0..4): when guess[i] == secret[i], set color i = green and used[i] = 1.
REQ-021 YELLOW SHALL take exactly 25 cycles (i outer, j inner, each 0..4).
REQ-022 In YELLOW, letter i is marked yellow at the lowest j meeting all of: color i is not yet set, used[j] = 0, and guess[i] == secret[j]; that j then gets used[j] = 1.
REQ-023 After YELLOW ends, SHALL mark every still-unset color gray.
REQ-024 WRITE SHALL take 1 cycle: hist_we = 1, hist_row = row, hist_data = {latched guess, colors}.
REQ-025 REPORT SHALL take 1 cycle: done = 1, row increments, win = 1 if colors == 10'h3FF, lose = 1 if win is not set and row+1 == MAX_GUESSES; then return to IDLE.
REQ-026 Latency SHALL be fixed: with start at edge E0, hist_we is high in cycle 31 and done is high in cycle 32.
REQ-027 SHALL ignore start while busy=1; it is not queued.
REQ-028 new_game while busy SHALL abort to IDLE on the next edge, clearing row, win, lose and colors, with no hist_we and no done.
REQ-029 row SHALL saturate at MAX_GUESSES and never wrap.
REQ-030 colors SHALL keep its value after done until the next valid start or new_game.

Reset
REQ-031 reset=1 SHALL immediately force state IDLE and set busy, done, err, hist_we, hist_row, hist_data, colors, row, win, lose and the used mask to 0, including in the middle of grading.
REQ-032 After reset is released, the first valid start SHALL be graded as row 0.

Verification
REQ-033 secret="CRANE", guess="CRANE", start -> hist_we in cycle 31 with hist_row=0, done in cycle 32, colors=10'h3FF, win=1, row=1; a later start -> no busy.
REQ-034 secret="CRANE", guess="EERIE" -> colors=10'h167 (gray, gray, yellow, gray, green), win=0, lose=0.
REQ-035 secret="ABBEY", guess="BOBBY" -> colors=10'h277 (yellow, gray, green, gray, green); this checks duplicate-letter consumption.
REQ-036 Six non-matching valid guesses -> lose=1 after the 6th done, row=6; a 7th start -> ignored.
REQ-037 guess="CR NE" (8'h20 at letter2) -> err pulse, busy stays 0, row unchanged, hist_we never asserted.
REQ-038 reset asserted in YELLOW cycle 10 -> all outputs 0 immediately, and no done pulse follows.
REQ-039 new_game asserted in GREEN -> busy falls on the next edge with no hist_we and no done.
